// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// the default bus timeout and a small state classification helper.
package data_mem_responder_pkg;

    localparam int TIMEOUT_CYC_DEF = 16;
    localparam int TMR_W           = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WR_BUS = 2'd1,
        ST_RD_BUS = 2'd2
    } state_e;

    function automatic logic is_bus_state(input state_e s);
        return (s == ST_WR_BUS) || (s == ST_RD_BUS);
    endfunction

endpackage

// File: rtl/data_mem_responder_bus_timer.sv
// Bus transaction watchdog: counts unacknowledged cycles and flags the cycle
// in which the transaction must be abandoned.
module bus_timer
    import data_mem_responder_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    assign expired_o = (cnt_q == TMR_W'(TIMEOUT_CYC - 1));

    // Next count: clear has priority; the count holds once expired.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {TMR_W{1'b0}};
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + TMR_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= {TMR_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Pipeline data-memory responder: serves reads from a one-entry buffer when
// possible, otherwise runs single bus transactions with a timeout.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADR_W       = 16,
    parameter int DAT_W       = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             mem_rd_en_i,
    input  logic [ADR_W-1:0] mem_rd_adr_i,
    input  logic             mem_wr_en_i,
    input  logic [ADR_W-1:0] mem_wr_adr_i,
    input  logic [DAT_W-1:0] mem_wr_dat_i,
    output logic [DAT_W-1:0] mem_rd_dat_o,
    output logic             mem_stl_o,
    output logic             mem_err_o,
    output logic             bus_req_o,
    output logic             bus_we_o,
    output logic [ADR_W-1:0] bus_adr_o,
    output logic [DAT_W-1:0] bus_wdat_o,
    input  logic             bus_ack_i,
    input  logic [DAT_W-1:0] bus_rdat_i
);

    state_e             state_q, state_d;
    logic [ADR_W-1:0]   wr_adr_q, wr_adr_d;
    logic [DAT_W-1:0]   wr_dat_q, wr_dat_d;
    logic [ADR_W-1:0]   rd_adr_q, rd_adr_d;
    logic               buf_vld_q, buf_vld_d;
    logic [ADR_W-1:0]   buf_adr_q, buf_adr_d;
    logic [DAT_W-1:0]   buf_dat_q, buf_dat_d;
    logic               err_d;
    logic               bus_req_q, bus_we_q;
    logic [ADR_W-1:0]   bus_adr_q;
    logic [DAT_W-1:0]   bus_wdat_q;
    logic [DAT_W-1:0]   rd_dat_s;
    logic               stl_s;
    logic               hit_s;
    logic               expired_s;
    logic               tmr_clr_s;
    logic               tmr_en_s;
    logic               err_q;

    assign hit_s     = buf_vld_q && (mem_rd_adr_i == buf_adr_q);
    assign tmr_clr_s = is_bus_state(state_d) && (state_d != state_q);
    assign tmr_en_s  = is_bus_state(state_q) && !bus_ack_i;

    bus_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_bus_timer (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (tmr_clr_s),
        .en_i      (tmr_en_s),
        .expired_o (expired_s)
    );

    // Next-state, buffer update and combinational pipeline responses.
    always_comb begin
        state_d   = state_q;
        wr_adr_d  = wr_adr_q;
        wr_dat_d  = wr_dat_q;
        rd_adr_d  = rd_adr_q;
        buf_vld_d = buf_vld_q;
        buf_adr_d = buf_adr_q;
        buf_dat_d = buf_dat_q;
        rd_dat_s  = {DAT_W{1'b0}};
        stl_s     = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_wr_en_i) begin
                    wr_adr_d = mem_wr_adr_i;
                    wr_dat_d = mem_wr_dat_i;
                    stl_s    = 1'b1;
                    state_d  = ST_WR_BUS;
                end else if (mem_rd_en_i && hit_s) begin
                    rd_dat_s = buf_dat_q;
                end else if (mem_rd_en_i) begin
                    rd_adr_d = mem_rd_adr_i;
                    stl_s    = 1'b1;
                    state_d  = ST_RD_BUS;
                end else begin
                    stl_s    = 1'b0;
                end
            end
            ST_RD_BUS: begin
                if (bus_ack_i) begin
                    rd_dat_s  = bus_rdat_i;
                    buf_vld_d = 1'b1;
                    buf_adr_d = rd_adr_q;
                    buf_dat_d = bus_rdat_i;
                    state_d   = ST_IDLE;
                end else if (expired_s) begin
                    rd_dat_s  = {DAT_W{1'b1}};
                    err_d     = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    stl_s     = 1'b1;
                end
            end
            ST_WR_BUS: begin
                if (bus_ack_i || expired_s) begin
                    err_d   = !bus_ack_i;
                    state_d = ST_IDLE;
                    if (bus_ack_i && buf_vld_q && (wr_adr_q == buf_adr_q)) begin
                        buf_dat_d = wr_dat_q;
                    end else begin
                        buf_dat_d = buf_dat_q;
                    end
                    // An aborted write never forwards its data to a pending read.
                    if (!mem_rd_en_i) begin
                        stl_s    = 1'b0;
                    end else if (bus_ack_i && (mem_rd_adr_i == wr_adr_q)) begin
                        rd_dat_s = wr_dat_q;
                    end else if (hit_s) begin
                        rd_dat_s = buf_dat_q;
                    end else begin
                        stl_s    = 1'b1;
                        rd_adr_d = mem_rd_adr_i;
                        state_d  = ST_RD_BUS;
                    end
                end else begin
                    stl_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_rd_dat_o = rd_dat_s;
    assign mem_stl_o    = stl_s && rst_n_i;
    assign mem_err_o    = err_q;
    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_we_q;
    assign bus_adr_o    = bus_adr_q;
    assign bus_wdat_o   = bus_wdat_q;

    // State, buffer and registered bus outputs with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            wr_adr_q   <= {ADR_W{1'b0}};
            wr_dat_q   <= {DAT_W{1'b0}};
            rd_adr_q   <= {ADR_W{1'b0}};
            buf_vld_q  <= 1'b0;
            buf_adr_q  <= {ADR_W{1'b0}};
            buf_dat_q  <= {DAT_W{1'b0}};
            err_q      <= 1'b0;
            bus_req_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_adr_q  <= {ADR_W{1'b0}};
            bus_wdat_q <= {DAT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            wr_adr_q   <= wr_adr_d;
            wr_dat_q   <= wr_dat_d;
            rd_adr_q   <= rd_adr_d;
            buf_vld_q  <= buf_vld_d;
            buf_adr_q  <= buf_adr_d;
            buf_dat_q  <= buf_dat_d;
            err_q      <= err_d;
            bus_req_q  <= is_bus_state(state_d);
            bus_we_q   <= (state_d == ST_WR_BUS);
            bus_adr_q  <= (state_d == ST_WR_BUS) ? wr_adr_d :
                          (state_d == ST_RD_BUS) ? rd_adr_d : {ADR_W{1'b0}};
            bus_wdat_q <= (state_d == ST_WR_BUS) ? wr_dat_d : {DAT_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, reset corner cases and
// randomized transactions against a transaction-level reference model.
module tb_data_mem_responder;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int T  = 16;

    logic          clk = 1'b0;
    logic          rst_n_i;
    logic          mem_rd_en_i, mem_wr_en_i;
    logic [AW-1:0] mem_rd_adr_i, mem_wr_adr_i;
    logic [DW-1:0] mem_wr_dat_i;
    logic [DW-1:0] mem_rd_dat_o;
    logic          mem_stl_o, mem_err_o;
    logic          bus_req_o, bus_we_o;
    logic [AW-1:0] bus_adr_o;
    logic [DW-1:0] bus_wdat_o;
    logic          bus_ack_i;
    logic [DW-1:0] bus_rdat_i;

    always #5 clk = ~clk;

    data_mem_responder #(.ADR_W(AW), .DAT_W(DW), .TIMEOUT_CYC(T)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .mem_rd_en_i  (mem_rd_en_i),
        .mem_rd_adr_i (mem_rd_adr_i),
        .mem_wr_en_i  (mem_wr_en_i),
        .mem_wr_adr_i (mem_wr_adr_i),
        .mem_wr_dat_i (mem_wr_dat_i),
        .mem_rd_dat_o (mem_rd_dat_o),
        .mem_stl_o    (mem_stl_o),
        .mem_err_o    (mem_err_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_adr_o    (bus_adr_o),
        .bus_wdat_o   (bus_wdat_o),
        .bus_ack_i    (bus_ack_i),
        .bus_rdat_i   (bus_rdat_i)
    );

    int n_vec = 0;
    int n_mis = 0;

    // Reference model state: the single buffered read line.
    bit            m_vld;
    logic [AW-1:0] m_adr;
    logic [DW-1:0] m_dat;
    bit            last_abort;

    typedef struct {
        bit            we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            re;
        logic [AW-1:0] ra;
        int            lw;
        int            lr;
        logic [DW-1:0] sdat;
        logic [DW-1:0] exp_rdat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One bus transaction; the slave acks in bus cycle 'lat' (never if lat > T).
    task automatic bus_phase(input bit we, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                             input int lat, input logic [DW-1:0] sdat, output bit ok);
        ok = 1'b0;
        for (int k = 1; k <= T; k++) begin
            @(posedge clk); #1;
            bus_ack_i  = (k == lat);
            bus_rdat_i = (k == lat) ? sdat : DW'($urandom);
            @(negedge clk);
            chk("bus_req", bus_req_o, 32'd1);
            chk("bus_we", bus_we_o, we);
            chk("bus_adr", bus_adr_o, adr);
            if (we) chk("bus_wdat", bus_wdat_o, wd);
            chk("err_in_phase", mem_err_o, (k == 1) && last_abort);
            if (k == lat || k == T) begin
                ok = (k == lat);
                last_abort = !ok;
                return;
            end
            chk("stall_busy", mem_stl_o, 32'd1);
        end
    endtask

    // One pipeline request from issue until it completes, then one idle cycle.
    task automatic run_txn(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                           input bit re, input logic [AW-1:0] ra, input int lw, input int lr,
                           input logic [DW-1:0] sdat, output logic [DW-1:0] got);
        bit            ok;
        bit            need_rd;
        logic [DW-1:0] exp_d;
        exp_d = 8'h00;
        got   = 8'h00;
        @(posedge clk); #1;
        mem_wr_en_i = we; mem_wr_adr_i = wa; mem_wr_dat_i = wd;
        mem_rd_en_i = re; mem_rd_adr_i = ra;
        bus_ack_i = 1'b0;
        last_abort = 1'b0;
        if (!we && re && m_vld && (ra == m_adr)) begin
            @(negedge clk);
            chk("hit_stall", mem_stl_o, 32'd0);
            chk("hit_rdat", mem_rd_dat_o, m_dat);
            chk("hit_bus_req", bus_req_o, 32'd0);
            got = mem_rd_dat_o;
        end else begin
            @(negedge clk);
            chk("issue_stall", mem_stl_o, 32'd1);
            chk("issue_bus_req", bus_req_o, 32'd0);
            need_rd = re;
            if (we) begin
                bus_phase(1'b1, wa, wd, lw, 8'h00, ok);
                if (ok && m_vld && (wa == m_adr)) m_dat = wd;
                if (re && ok && (ra == wa)) begin
                    exp_d = wd; need_rd = 1'b0;
                end else if (re && m_vld && (ra == m_adr)) begin
                    exp_d = m_dat; need_rd = 1'b0;
                end
                if (need_rd) begin
                    chk("wr_end_stall", mem_stl_o, 32'd1);
                end else begin
                    chk("wr_end_stall", mem_stl_o, 32'd0);
                    if (re) chk("wr_end_rdat", mem_rd_dat_o, exp_d);
                    got = mem_rd_dat_o;
                end
            end
            if (need_rd) begin
                bus_phase(1'b0, ra, 8'h00, lr, sdat, ok);
                if (ok) begin
                    exp_d = sdat; m_vld = 1'b1; m_adr = ra; m_dat = sdat;
                end else begin
                    exp_d = 8'hFF;
                end
                chk("rd_end_stall", mem_stl_o, 32'd0);
                chk("rd_end_rdat", mem_rd_dat_o, exp_d);
                got = mem_rd_dat_o;
            end
        end
        @(posedge clk); #1;
        mem_wr_en_i = 1'b0; mem_rd_en_i = 1'b0; bus_ack_i = 1'b0;
        @(negedge clk);
        chk("post_err", mem_err_o, last_abort);
        chk("idle_stall", mem_stl_o, 32'd0);
        chk("idle_rdat", mem_rd_dat_o, 32'd0);
        chk("idle_bus_req", bus_req_o, 32'd0);
    endtask

    vec_t          vecs[14];
    logic [DW-1:0] got;
    logic [AW-1:0] pool[4];

    initial begin
        vecs[0]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'h1234, 0, 3,  8'h5A, 8'h5A};
        vecs[1]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'h1234, 0, 0,  8'h00, 8'h5A};
        vecs[2]  = '{1'b1, 16'h1234, 8'hC3, 1'b0, 16'h0000, 2, 0,  8'h00, 8'h00};
        vecs[3]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'h1234, 0, 0,  8'h00, 8'hC3};
        vecs[4]  = '{1'b1, 16'h0200, 8'h11, 1'b1, 16'h0200, 1, 0,  8'h00, 8'h11};
        vecs[5]  = '{1'b1, 16'h0201, 8'h22, 1'b1, 16'h0300, 2, 2,  8'h77, 8'h77};
        vecs[6]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'h4000, 0, 99, 8'h00, 8'hFF};
        vecs[7]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'h0300, 0, 0,  8'h00, 8'h77};
        vecs[8]  = '{1'b1, 16'h0300, 8'h44, 1'b0, 16'h0000, 99, 0, 8'h00, 8'h00};
        vecs[9]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'h0300, 0, 0,  8'h00, 8'h77};
        vecs[10] = '{1'b1, 16'h0300, 8'h66, 1'b1, 16'h0300, 99, 0, 8'h00, 8'h77};
        vecs[11] = '{1'b1, 16'h0300, 8'h55, 1'b0, 16'h0000, 16, 0, 8'h00, 8'h00};
        vecs[12] = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'h0300, 0, 0,  8'h00, 8'h55};
        vecs[13] = '{1'b1, 16'h0777, 8'h01, 1'b1, 16'h0888, 3, 99, 8'h00, 8'hFF};
        pool[0] = 16'h0010; pool[1] = 16'h0011; pool[2] = 16'h1234; pool[3] = 16'hABCD;

        rst_n_i = 1'b0;
        mem_rd_en_i = 1'b1; mem_rd_adr_i = 16'h0001;
        mem_wr_en_i = 1'b0; mem_wr_adr_i = '0; mem_wr_dat_i = '0;
        bus_ack_i = 1'b0; bus_rdat_i = '0;
        m_vld = 1'b0; m_adr = '0; m_dat = '0; last_abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", mem_stl_o, 32'd0);
        chk("rst_bus_req", bus_req_o, 32'd0);
        chk("rst_bus_we", bus_we_o, 32'd0);
        chk("rst_bus_adr", bus_adr_o, 32'd0);
        chk("rst_bus_wdat", bus_wdat_o, 32'd0);
        chk("rst_err", mem_err_o, 32'd0);
        @(posedge clk); #1;
        rst_n_i = 1'b1; mem_rd_en_i = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_txn(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra,
                    vecs[i].lw, vecs[i].lr, vecs[i].sdat, got);
            if (vecs[i].re) chk($sformatf("table_rdat[%0d]", i), got, vecs[i].exp_rdat);
        end

        // Reset while a read is outstanding; a late ack must be ignored.
        @(posedge clk); #1;
        mem_rd_en_i = 1'b1; mem_rd_adr_i = 16'h0500;
        @(negedge clk);
        chk("rr_issue_stall", mem_stl_o, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rr_bus_req", bus_req_o, 32'd1);
        @(posedge clk); #1;
        rst_n_i = 1'b0;
        @(negedge clk);
        chk("rr_stall_in_rst", mem_stl_o, 32'd0);
        @(posedge clk); #1;
        rst_n_i = 1'b1; mem_rd_en_i = 1'b0; bus_ack_i = 1'b1; bus_rdat_i = 8'hEE;
        @(negedge clk);
        chk("rr_bus_req_drop", bus_req_o, 32'd0);
        chk("rr_late_ack_stall", mem_stl_o, 32'd0);
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
        @(negedge clk);
        chk("rr_after_ack_req", bus_req_o, 32'd0);
        chk("rr_after_ack_err", mem_err_o, 32'd0);
        m_vld = 1'b0; m_adr = '0; m_dat = '0;
        run_txn(1'b0, 16'h0000, 8'h00, 1'b1, 16'h0300, 0, 2, 8'h3C, got);
        chk("rr_reread_miss", got, 32'h3C);

        for (int i = 0; i < 150; i++) begin
            bit we, re;
            we = 1'($urandom);
            re = 1'($urandom);
            if (!we && !re) re = 1'b1;
            run_txn(we, pool[$urandom_range(0, 3)], DW'($urandom), re, pool[$urandom_range(0, 3)],
                    $urandom_range(1, 18), $urandom_range(1, 18), DW'($urandom), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADR_W, default 16: CPU and bus address width.
REQ-002 Parameter DAT_W, default 8: data width.
REQ-003 Parameter TIMEOUT_CYC, default 16: maximum cycles waited for bus_ack_i, range 1..255.
REQ-004 The block SHALL use one clock and a synchronous, active-low reset (ports clk_i, rst_n_i).
REQ-005 Ports SHALL be, clock and reset first:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous reset, active low
- mem_rd_en_i  in  1  pipeline read request
- mem_rd_adr_i  in  ADR_W  read address
- mem_wr_en_i  in  1  pipeline write request
- mem_wr_adr_i  in  ADR_W  write address
- mem_wr_dat_i  in  DAT_W  write data
- mem_rd_dat_o  out  DAT_W  read data, combinational
- mem_stl_o  out  1  stall to pipeline, combinational
- mem_err_o  out  1  one-cycle timeout pulse, registered
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = write
- bus_adr_o  out  ADR_W  bus address
- bus_wdat_o  out  DAT_W  bus write data
- bus_ack_i  in  1  bus completion, one cycle
- bus_rdat_i  in  DAT_W  bus read data, valid with bus_ack_i

Function
REQ-006 The block SHALL implement three states, IDLE, WR_BUS and RD_BUS, plus a one-entry read buffer (buf_vld, buf_adr, buf_dat).
REQ-007 Hit SHALL be defined as buf_vld & (mem_rd_adr_i == buf_adr).
REQ-008 IDLE, mem_wr_en_i=1:
- latch wr adr/dat
- go to WR_BUS
- mem_stl_o=1
- writes take priority over a same-cycle read
REQ-009 IDLE, mem_rd_en_i=1, no write, hit:
- mem_rd_dat_o=buf_dat, mem_stl_o=0
- no bus activity
- zero-cycle latency
REQ-010 IDLE, mem_rd_en_i=1, no write, miss:
- latch rd adr
- mem_stl_o=1
- go to RD_BUS
REQ-011 IDLE, no request: mem_stl_o=0; mem_rd_dat_o=0.
REQ-012 WR_BUS and RD_BUS SHALL be registered bus outputs:
- bus_req_o=1
- bus_adr_o = latched address
- bus_we_o=1 only in WR_BUS
- bus_wdat_o = latched data
REQ-013 RD_BUS, bus_ack_i=1:
- mem_rd_dat_o=bus_rdat_i, mem_stl_o=0 in the same cycle
- buffer loaded {1, adr, bus_rdat_i}
- next state IDLE
REQ-014 RD_BUS without ack: mem_stl_o=1.
REQ-015 WR_BUS, bus_ack_i=1, no read pending: mem_stl_o=0; next state IDLE.
REQ-016 WR_BUS ack with buf_vld and wr adr == buf_adr: buf_dat SHALL be updated to the written data.
REQ-017 WR_BUS ack with mem_rd_en_i=1:
- rd adr == wr adr: mem_rd_dat_o = written data, stall 0, next IDLE
- else hit: buf_dat returned, stall 0, next IDLE
- else: stall 1, rd adr latched, next RD_BUS
REQ-018 WR_BUS without ack: mem_stl_o=1.
REQ-019 Timeout counter:
- cleared on every entry to WR_BUS/RD_BUS
- increments each cycle without ack
- at count == TIMEOUT_CYC-1 without ack, the transaction SHALL abort
REQ-020 Abort in RD_BUS:
- mem_rd_dat_o=8'hFF, mem_stl_o=0
- buffer unchanged
- mem_err_o=1 next cycle
- next IDLE
REQ-021 Abort in WR_BUS:
- write discarded, buffer unchanged
- mem_err_o=1 next cycle
- pending read handled per REQ-017 with the write treated as absent
REQ-022 Ack in the abort cycle SHALL count as success.
REQ-023 bus_ack_i SHALL be ignored in IDLE.
REQ-024 Request inputs SHALL be held stable by the pipeline while mem_stl_o=1; the block does not re-sample them then.

Reset
REQ-025 rst_n_i=0 at a clock edge SHALL set:
- state IDLE
- buf_vld=0, buf_adr=0, buf_dat=0
- counter 0
- bus_req_o, bus_we_o, bus_adr_o, bus_wdat_o, mem_err_o = 0
REQ-026 Reset mid-transaction SHALL drop bus_req_o on the next edge; a later ack is ignored.
REQ-027 During reset, mem_stl_o SHALL be 0.

Structure
REQ-028 State encodings and the TIMEOUT_CYC default SHALL be defined in Global_Macros.v.
REQ-029 The timeout counter SHALL be one sub-module, bus_timer (inputs clr, en; output expired).
REQ-030 Target size is 150-300 RTL lines.

Verification
REQ-031 Miss then hit:
- read 0x1234, ack after 3 cycles with 0x5A -> stall 1 for 3 cycles, 0x5A in the ack cycle
- re-read 0x1234 -> 0x5A, stall 0, bus_req_o 0
REQ-032 Write updating the buffer: buffer {0x1234,0x5A}, write 0x1234=0xC3, ack after 2 cycles -> bus_we_o=1, then read 0x1234 hits with 0xC3.
REQ-033 Simultaneous write and read:
- write 0x0200=0x11, read 0x0200 -> one WR_BUS transaction, read returns 0x11 on the write ack, stall drops in that cycle
- read 0x0300 instead -> a second RD_BUS transaction follows
REQ-034 Timeout: read 0x4000, no ack -> stall 1 for 15 cycles, cycle 16 returns 0xFF with stall 0, mem_err_o pulses once, buffer unchanged.
REQ-035 Reset mid-read: rst_n_i=0 during RD_BUS -> bus_req_o 0 next edge, buf_vld 0, late ack ignored, next read of the same address misses.
